flag_branch_ctrl: RTL and testbench

FLAG_BRANCH_CTRL -- requirements
Module: flag_branch_ctrl

---
 rtl/wisc_br_pkg.sv | 26 ++
 rtl/branch_cond_eval.sv | 34 +++
 rtl/flag_branch_ctrl.sv | 114 +++++++++++
 tb/tb_flag_branch_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_br_pkg.sv
// Shared definitions for the flag-based branch controller: condition codes,
// controller states and flag bit positions.
package wisc_br_pkg;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    CCC_NEQ    = 3'b000,
    CCC_EQ     = 3'b001,
    CCC_GT     = 3'b010,
    CCC_LT     = 3'b011,
    CCC_GTE    = 3'b100,
    CCC_LTE    = 3'b101,
    CCC_OVFL   = 3'b110,
    CCC_UNCOND = 3'b111
  } ccc_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: maps a condition code and a
// Z,V,N flag vector to a taken/not-taken decision.
module branch_cond_eval
  import wisc_br_pkg::*;
(
  input  logic [2:0] i_ccc,
  input  logic [2:0] i_flags,
  output logic       o_taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = i_flags[FLAG_Z];
  assign w_v = i_flags[FLAG_V];
  assign w_n = i_flags[FLAG_N];

  always_comb begin
    o_taken = 1'b0;
    case (ccc_e'(i_ccc))
      CCC_NEQ:    o_taken = ~w_z;
      CCC_EQ:     o_taken = w_z;
      CCC_GT:     o_taken = ~w_z & ~w_n;
      CCC_LT:     o_taken = w_n;
      CCC_GTE:    o_taken = w_z | (~w_z & ~w_n);
      CCC_LTE:    o_taken = w_z | w_n;
      CCC_OVFL:   o_taken = w_v;
      CCC_UNCOND: o_taken = 1'b1;
      default:    o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Branch resolution controller for the ID stage with a Z,V,N flag register.
// Define FLAG_FORWARD_EN to forward EX flag writes instead of stalling.
module flag_branch_ctrl
  import wisc_br_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid_id,
  input  logic [2:0]      br_ccc,
  input  logic [PC_W-1:0] br_target,
  input  logic            ex_valid,
  input  logic [2:0]      flag_we_ex,
  input  logic [2:0]      flag_new_ex,
  output logic            stall_out,
  output logic            flush_out,
  output logic            pc_redirect,
  output logic [PC_W-1:0] pc_target,
  output logic [2:0]      flags
);

  state_e          r_state;
  state_e          w_next;
  logic [2:0]      r_flags;
  logic [2:0]      w_flagWe;
  logic [2:0]      w_fwdFlags;
  logic [2:0]      w_evalFlags;
  logic            w_taken;
  logic            w_decide;
  logic            r_redirect;
  logic            r_flush;
  logic [PC_W-1:0] r_target;

  // Flag register input: bits written by EX take the new value, others hold.
  assign w_flagWe   = {3{ex_valid}} & flag_we_ex;
  assign w_fwdFlags = (w_flagWe & flag_new_ex) | (~w_flagWe & r_flags);

`ifdef FLAG_FORWARD_EN
  assign w_evalFlags = (r_state == ST_RUN) ? w_fwdFlags : r_flags;
  assign stall_out   = 1'b0;
`else
  logic w_hazard;
  logic w_stall;

  assign w_hazard    = br_valid_id & ex_valid & (|flag_we_ex) & (br_ccc != CCC_UNCOND);
  assign w_evalFlags = r_flags;
  assign stall_out   = w_stall & rst_n;
`endif

  branch_cond_eval u_cond (
    .i_ccc   (br_ccc),
    .i_flags (w_evalFlags),
    .o_taken (w_taken)
  );

  always_comb begin
    w_next   = r_state;
    w_decide = 1'b0;
`ifndef FLAG_FORWARD_EN
    w_stall  = 1'b0;
`endif
    case (r_state)
      ST_RUN: begin
        if (br_valid_id) begin
`ifdef FLAG_FORWARD_EN
          w_decide = 1'b1;
`else
          if (w_hazard) begin
            w_stall = 1'b1;
            w_next  = ST_STALL;
          end else begin
            w_decide = 1'b1;
          end
`endif
        end
      end
      // The held branch resolves against flags that already include the EX write.
      ST_STALL: begin
        w_decide = 1'b1;
        w_next   = ST_RUN;
      end
      ST_FLUSH: w_next = ST_RUN;
      default:  w_next = ST_RUN;
    endcase
    if (w_decide && w_taken) begin
      w_next = ST_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_flags    <= 3'b000;
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      r_target   <= '0;
    end else begin
      r_state    <= w_next;
      r_flags    <= w_fwdFlags;
      r_redirect <= (w_next == ST_FLUSH);
      r_flush    <= (w_next == ST_FLUSH);
      if (w_next == ST_FLUSH) begin
        r_target <= br_target;
      end
    end
  end

  assign pc_redirect = r_redirect;
  assign flush_out   = r_flush;
  assign pc_target   = r_target;
  assign flags       = r_flags;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Self-checking bench for flag_branch_ctrl: directed scenarios, a full
// condition sweep and randomized traffic against a behavioural model.
module tb_flag_branch_ctrl;

  localparam int PC_W = 16;
`ifdef FLAG_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            br_valid_id;
  logic [2:0]      br_ccc;
  logic [PC_W-1:0] br_target;
  logic            ex_valid;
  logic [2:0]      flag_we_ex;
  logic [2:0]      flag_new_ex;
  logic            stall_out;
  logic            flush_out;
  logic            pc_redirect;
  logic [PC_W-1:0] pc_target;
  logic [2:0]      flags;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: architectural flags, whether a branch is being held
  // by a stall, whether the current cycle is the wrong-path flush slot.
  logic [2:0]      mFlags;
  bit              mHeld;
  bit              mInFlush;
  logic [PC_W-1:0] mTarget;
  logic [2:0]      heldCcc;
  logic [PC_W-1:0] heldTarget;

  flag_branch_ctrl #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_valid_id (br_valid_id),
    .br_ccc      (br_ccc),
    .br_target   (br_target),
    .ex_valid    (ex_valid),
    .flag_we_ex  (flag_we_ex),
    .flag_new_ex (flag_new_ex),
    .stall_out   (stall_out),
    .flush_out   (flush_out),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  // Taken rule from the condition table, expressed as compare relations.
  function automatic bit refTaken(input logic [2:0] ccc, input logic [2:0] f);
    bit eq, lt, gt, ovf;
    eq  = (f[2] == 1'b1);
    lt  = (f[0] == 1'b1);
    gt  = !eq && !lt;
    ovf = (f[1] == 1'b1);
    case (ccc)
      3'd0:    return !eq;
      3'd1:    return eq;
      3'd2:    return gt;
      3'd3:    return lt;
      3'd4:    return eq || gt;
      3'd5:    return eq || lt;
      3'd6:    return ovf;
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mFlags   = 3'b000;
    mHeld    = 1'b0;
    mInFlush = 1'b0;
    mTarget  = '0;
  endtask

  task automatic driveIdle();
    br_valid_id = 1'b0;
    br_ccc      = 3'b000;
    br_target   = '0;
    ex_valid    = 1'b0;
    flag_we_ex  = 3'b000;
    flag_new_ex = 3'b000;
  endtask

  // One clock cycle: drive at negedge, check stall before the edge,
  // advance the model at the edge, check registered outputs just after.
  task automatic applyStimulus(input bit bv, input logic [2:0] ccc, input logic [PC_W-1:0] tgt,
                               input bit exv, input logic [2:0] we, input logic [2:0] nw);
    bit         expStall;
    bit         decide;
    bit         nextFlush;
    bit         nextHeld;
    logic [2:0] f;
    @(negedge clk);
    if (mHeld) begin
      bv  = 1'b1;
      ccc = heldCcc;
      tgt = heldTarget;
    end
    br_valid_id = bv;
    br_ccc      = ccc;
    br_target   = tgt;
    ex_valid    = exv;
    flag_we_ex  = we;
    flag_new_ex = nw;
    expStall  = 1'b0;
    decide    = 1'b0;
    nextFlush = 1'b0;
    nextHeld  = 1'b0;
    f         = mFlags;
    if (mInFlush) begin
      decide = 1'b0;
    end else if (mHeld) begin
      decide = 1'b1;
    end else if (bv) begin
      if (exv && we != 3'b000 && ccc != 3'b111 && !FWD) begin
        expStall = 1'b1;
        nextHeld = 1'b1;
      end else begin
        decide = 1'b1;
        if (exv) f = (mFlags & ~we) | (nw & we);
      end
    end
    if (decide && refTaken(ccc, f)) nextFlush = 1'b1;
    #1;
    checkOutput("stall_out", {31'd0, stall_out}, {31'd0, expStall});
    @(posedge clk);
    mInFlush = nextFlush;
    mHeld    = nextHeld;
    if (nextFlush) mTarget = tgt;
    if (exv) mFlags = (mFlags & ~we) | (nw & we);
    heldCcc    = ccc;
    heldTarget = tgt;
    #1;
    checkOutput("pc_redirect", {31'd0, pc_redirect}, {31'd0, mInFlush});
    checkOutput("flush_out", {31'd0, flush_out}, {31'd0, mInFlush});
    checkOutput("pc_target", {16'd0, pc_target}, {16'd0, mTarget});
    checkOutput("flags", {29'd0, flags}, {29'd0, mFlags});
  endtask

  initial begin
    rst_n = 1'b0;
    driveIdle();
    modelReset();
    heldCcc    = 3'b000;
    heldTarget = '0;
    #12;
    checkOutput("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush_out}, 32'd0);
    checkOutput("rst_target", {16'd0, pc_target}, 32'd0);
    checkOutput("rst_flags", {29'd0, flags}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flags 000 via EX, then EQ branch with no hazard: not taken.
    applyStimulus(1'b0, 3'b000, 16'h0000, 1'b1, 3'b111, 3'b000);
    applyStimulus(1'b1, 3'b001, 16'h0010, 1'b0, 3'b000, 3'b000);
    checkOutput("eq_not_taken", {31'd0, pc_redirect}, 32'd0);

    // EX sets Z in the branch cycle: stall (unless forwarding), then redirect.
    applyStimulus(1'b1, 3'b001, 16'h0040, 1'b1, 3'b100, 3'b100);
`ifndef FLAG_FORWARD_EN
    checkOutput("hazard_no_early_redirect", {31'd0, pc_redirect}, 32'd0);
    applyStimulus(1'b1, 3'b001, 16'h0040, 1'b0, 3'b000, 3'b000);
`endif
    checkOutput("hazard_redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("hazard_target", {16'd0, pc_target}, 32'h0040);
    applyStimulus(1'b0, 3'b000, 16'h0000, 1'b0, 3'b000, 3'b000);

    // Unconditional branch with a concurrent flag write, then a wrong-path branch.
    applyStimulus(1'b1, 3'b111, 16'h0123, 1'b1, 3'b111, 3'b010);
    checkOutput("uncond_redirect", {31'd0, pc_redirect}, 32'd1);
    applyStimulus(1'b1, 3'b111, 16'h0200, 1'b0, 3'b000, 3'b000);
    checkOutput("flush_slot_ignored", {31'd0, pc_redirect}, 32'd0);
    checkOutput("flush_slot_target", {16'd0, pc_target}, 32'h0123);

    // Every condition code against every flag combination.
    for (int fl = 0; fl < 8; fl++) begin
      for (int c = 0; c < 8; c++) begin
        applyStimulus(1'b0, 3'b000, 16'h0000, 1'b1, 3'b111, 3'(fl));
        applyStimulus(1'b1, 3'(c), 16'(16'h1000 + fl * 8 + c), 1'b0, 3'b000, 3'b000);
        applyStimulus(1'b0, 3'b000, 16'h0000, 1'b0, 3'b000, 3'b000);
      end
    end

    // Reset pulsed while a branch is held by a stall.
    applyStimulus(1'b0, 3'b000, 16'h0000, 1'b1, 3'b111, 3'b000);
    applyStimulus(1'b1, 3'b000, 16'h0777, 1'b1, 3'b100, 3'b000);
    #2;
    br_valid_id = 1'b1;
    br_ccc      = 3'b001;
    ex_valid    = 1'b1;
    flag_we_ex  = 3'b111;
    flag_new_ex = 3'b111;
    rst_n       = 1'b0;
    #1;
    checkOutput("midrst_stall", {31'd0, stall_out}, 32'd0);
    checkOutput("midrst_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("midrst_flush", {31'd0, flush_out}, 32'd0);
    checkOutput("midrst_flags", {29'd0, flags}, 32'd0);
    checkOutput("midrst_target", {16'd0, pc_target}, 32'd0);
    modelReset();
    driveIdle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'b000, 16'h0000, 1'b0, 3'b000, 3'b000);
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
